// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and the
// frame-length helper. Frame length follows the optional parity feature,
// enabled by defining SIPO_DESERIALIZER_PARITY_EN.
package sipo_pkg;

    // FILL: shifter accepting bits; FULL: shifter holds a finished word
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } sipo_state_e;

    // Serial bits per frame: data bits, plus one trailing parity bit if enabled
    function automatic int unsigned sipo_flen(input int unsigned width);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_shifter.sv
// Serial shifter and bit counter for one frame.
// Ports:
//   clk, clr        clock, synchronous active-high reset
//   i_bit           serial data bit
//   i_accept        bit is accepted this cycle
//   o_word_c        shifter contents including a data bit accepted this cycle
//   o_frame_done_c  last bit of the frame is accepted this cycle
//   o_par_c         XOR of every bit of the frame so far, including this cycle's
// Macro SIPO_DESERIALIZER_PARITY_EN: frame carries a trailing parity bit that is
// counted and folded into o_par_c but never shifted into the word.
module sipo_shifter
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_bit,
    input  logic             i_accept,
    output logic [WIDTH-1:0] o_word_c,
    output logic             o_frame_done_c,
    output logic             o_par_c
);

    localparam int unsigned FLEN  = sipo_flen(WIDTH);
    localparam int unsigned CNT_W = $clog2(FLEN);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_last;
    logic             w_data_bit;

    assign w_last     = (r_cnt == CNT_W'(FLEN - 1));
    // Only the first WIDTH bits of a frame are data; a parity bit is not shifted
    assign w_data_bit = ({1'b0, r_cnt} < (CNT_W + 1)'(WIDTH));

    // Shift direction decides which end of q receives the first bit
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_shift_next = {i_bit, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Bypass lets the top load a word on the same edge as its last data bit
    assign o_word_c       = (i_accept && w_data_bit) ? w_shift_next : r_shift;
    assign o_frame_done_c = i_accept && w_last;

`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic r_par;

    assign o_par_c = r_par ^ (i_accept & i_bit);

    // Running XOR of the frame, cleared at frame boundary
    always_ff @(posedge clk) begin
        if (clr) begin
            r_par <= 1'b0;
        end else if (i_accept) begin
            r_par <= w_last ? 1'b0 : (r_par ^ i_bit);
        end
    end
`else
    assign o_par_c = 1'b0;
`endif

    // Shifter and bit counter; the finished word stays in r_shift until reloaded
    always_ff @(posedge clk) begin
        if (clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_accept) begin
            if (w_data_bit) begin
                r_shift <= w_shift_next;
            end
            r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word output buffer.
// Ports:
//   clk, clr     clock, synchronous active-high reset
//   sin          serial data bit, qualified by sin_valid / sin_ready
//   q            assembled word, qualified by q_valid / q_ready
//   parity_err   parity flag registered with q (0 unless parity is enabled)
//   word_cnt     words accepted downstream, wraps modulo 2^CNT_W
// Macro SIPO_DESERIALIZER_PARITY_EN: each frame carries a trailing even-parity
// bit; parity_err reports the XOR of data and parity bits.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             parity_err,
    output logic [CNT_W-1:0] word_cnt
);

    sipo_state_e      r_state;
    sipo_state_e      w_state_next;
    logic             r_sin_ready;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_parity_err;
    logic             r_pend_err;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_accept;
    logic             w_out_free;
    logic             w_load;
    logic             w_load_err;
    logic [WIDTH-1:0] w_word_c;
    logic             w_frame_done_c;
    logic             w_par_c;

    assign w_accept   = sin_valid && r_sin_ready;
    assign w_out_free = !r_q_valid || q_ready;

    sipo_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk            (clk),
        .clr            (clr),
        .i_bit          (sin),
        .i_accept       (w_accept),
        .o_word_c       (w_word_c),
        .o_frame_done_c (w_frame_done_c),
        .o_par_c        (w_par_c)
    );

    // State register; sin_ready is registered as a decode of the next state
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_FILL;
            r_sin_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_sin_ready <= (w_state_next == ST_FILL);
        end
    end

    // Next state: park in FULL only when a word finishes behind a stalled q
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: if (w_frame_done_c && !w_out_free) w_state_next = ST_FULL;
            ST_FULL: if (w_out_free)                    w_state_next = ST_FILL;
            default: w_state_next = ST_FILL;
        endcase
    end

    // Output decode: when to load q, and which parity result goes with it
    always_comb begin
        w_load     = 1'b0;
        w_load_err = w_par_c;
        case (r_state)
            ST_FILL: w_load = w_frame_done_c && w_out_free;
            ST_FULL: begin
                w_load     = w_out_free;
                w_load_err = r_pend_err;
            end
            default: w_load = 1'b0;
        endcase
    end

    // Parity of a word parked in the shifter while q is stalled
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pend_err <= 1'b0;
        end else if (w_frame_done_c) begin
            r_pend_err <= w_par_c;
        end
    end

    // Output buffer and delivered-word counter
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q          <= '0;
            r_q_valid    <= 1'b0;
            r_parity_err <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            if (r_q_valid && q_ready) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_q          <= w_word_c;
                r_q_valid    <= 1'b1;
                r_parity_err <= w_load_err;
            end else if (q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign sin_ready  = r_sin_ready;
    assign q          = r_q;
    assign q_valid    = r_q_valid;
    assign parity_err = r_parity_err;
    assign word_cnt   = r_word_cnt;

endmodule
